reg_exec_controller: RTL and testbench

- Multi-cycle execute/writeback controller for the single-cycle processor's 4-entry register file.
- Accepts one register-to-register instruction over a valid/ready handshake and drives the register file's read addresses.
- Latches RD1/RD2 and computes the ALU result, then drives write-back (A3, WD3, WE3) into the same register file.
- Sits directly upstream and downstream of the register file.
- Optionally maintains an NZCV flag register.

---
 rtl/reg_exec_controller_if.sv | 30 +++
 rtl/reg_exec_controller.sv | 158 +++++++++++++++
 tb/tb_reg_exec_controller.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/reg_exec_controller_if.sv
// Handshake and register-file bundle between the execute/writeback controller,
// its instruction source and the 4-entry register file.
interface reg_exec_controller_if #(
    parameter int W = 4
) ();
    logic [7:0]   instr;
    logic         instr_valid;
    logic         instr_ready;
    logic [1:0]   A1;
    logic [1:0]   A2;
    logic [W-1:0] RD1;
    logic [W-1:0] RD2;
    logic [1:0]   A3;
    logic [W-1:0] WD3;
    logic         WE3;
    logic         done;
    logic [3:0]   flags;

    // The controller side: consumes instructions and read data, drives addresses and write-back.
    modport slave (
        input  instr, instr_valid, RD1, RD2,
        output instr_ready, A1, A2, A3, WD3, WE3, done, flags
    );

    // The environment side: instruction source plus register file.
    modport master (
        output instr, instr_valid, RD1, RD2,
        input  instr_ready, A1, A2, A3, WD3, WE3, done, flags
    );
endinterface

// File: rtl/reg_exec_controller.sv
// Four-state execute/writeback controller for a 4-entry register file (IDLE/READ/EXEC/WRITE).
// Define REG_EXEC_FLAGS_EN to build the NZCV flag register; otherwise flags is tied to zero.
module reg_exec_controller #(
    parameter int W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    reg_exec_controller_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_EXEC  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_ORR = 2'b11;

    state_t              r_state;
    state_t              w_next;
    logic                w_ready;
    logic                w_write;
    logic                w_accept;

    logic [7:0]          r_hold_p0;
    logic signed [W-1:0] r_op_a_p1;
    logic signed [W-1:0] r_op_b_p1;
    logic [W-1:0]        r_result_p2;

    function automatic logic [W-1:0] alu_f(
        input logic [1:0]          op,
        input logic signed [W-1:0] a,
        input logic signed [W-1:0] b
    );
        logic [W-1:0] res;
        res = '0;
        case (op)
            OP_ADD:  res = a + b;
            OP_SUB:  res = a + ~b + W'(1);
            OP_AND:  res = a & b;
            default: res = a | b;
        endcase
        return res;
    endfunction

`ifdef REG_EXEC_FLAGS_EN
    // The W+1 bit sum exposes the carry; SUB carry is the inverted borrow.
    function automatic logic [3:0] nzcv_f(
        input logic [1:0]          op,
        input logic signed [W-1:0] a,
        input logic signed [W-1:0] b
    );
        logic [W:0] sum;
        logic       c;
        logic       v;
        sum = '0;
        c   = 1'b0;
        v   = 1'b0;
        case (op)
            OP_ADD: begin
                sum = {1'b0, a} + {1'b0, b};
                c   = sum[W];
                v   = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
            end
            OP_SUB: begin
                sum = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
                c   = sum[W];
                v   = (a[W-1] != b[W-1]) && (sum[W-1] != a[W-1]);
            end
            OP_AND:  sum = {1'b0, a & b};
            default: sum = {1'b0, a | b};
        endcase
        return {sum[W-1], (sum[W-1:0] == '0), c, v};
    endfunction
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        w_write = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (bus.instr_valid) begin
                    w_next = S_READ;
                end
            end
            S_READ:  w_next = S_EXEC;
            S_EXEC:  w_next = S_WRITE;
            S_WRITE: begin
                w_write = 1'b1;
                w_next  = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_accept = w_ready && bus.instr_valid;

    // Stage p0: instruction hold; p1: operands from the register file; p2: ALU result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_p0   <= '0;
            r_op_a_p1   <= '0;
            r_op_b_p1   <= '0;
            r_result_p2 <= '0;
        end else begin
            if (w_accept) begin
                r_hold_p0 <= bus.instr;
            end
            if (r_state == S_READ) begin
                r_op_a_p1 <= bus.RD1;
                r_op_b_p1 <= bus.RD2;
            end
            if (r_state == S_EXEC) begin
                r_result_p2 <= alu_f(r_hold_p0[7:6], r_op_a_p1, r_op_b_p1);
            end
        end
    end

`ifdef REG_EXEC_FLAGS_EN
    logic [3:0] r_flags_p2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flags_p2 <= 4'b0000;
        end else if (r_state == S_EXEC) begin
            r_flags_p2 <= nzcv_f(r_hold_p0[7:6], r_op_a_p1, r_op_b_p1);
        end
    end

    assign bus.flags = r_flags_p2;
`else
    assign bus.flags = 4'b0000;
`endif

    // Addresses come straight from the hold register so they keep their last value when idle.
    assign bus.instr_ready = w_ready;
    assign bus.A1          = r_hold_p0[3:2];
    assign bus.A2          = r_hold_p0[1:0];
    assign bus.A3          = r_hold_p0[5:4];
    assign bus.WD3         = r_result_p2;
    assign bus.WE3         = w_write;
    assign bus.done        = w_write;

endmodule

// File: tb/tb_reg_exec_controller.sv
// Directed bench for reg_exec_controller: register-file model, transaction-level reference
// model with a per-cycle compare process, and hand-computed literal expectations.
module tb_reg_exec_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_exec_controller_if #(.W(4)) bus ();

    reg_exec_controller #(.W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int pulses[$];

    logic [3:0] regs [4];
    logic       pl_en = 1'b0;
    logic [1:0] pl_a  = 2'd0;
    logic [3:0] pl_d  = 4'd0;

    assign bus.RD1 = regs[bus.A1];
    assign bus.RD2 = regs[bus.A2];

    always @(posedge clk) begin
        if (pl_en) regs[pl_a] <= pl_d;
        else if (bus.WE3) regs[bus.A3] <= bus.WD3;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        else n_pass++;
    endtask

    // Reference: {N,Z,C,V,result} from plain integer arithmetic on the operand values.
    function automatic logic [7:0] model_exec(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        int ua, ub, sa, sb, r, s;
        logic c, v;
        ua = a; ub = b;
        sa = (ua >= 8) ? ua - 16 : ua;
        sb = (ub >= 8) ? ub - 16 : ub;
        c = 1'b0; v = 1'b0; r = 0;
        case (op)
            2'd0: begin r = (ua + ub) % 16; c = (ua + ub) >= 16; s = sa + sb; v = (s > 7) || (s < -8); end
            2'd1: begin r = (ua - ub + 16) % 16; c = ua >= ub; s = sa - sb; v = (s > 7) || (s < -8); end
            2'd2: r = ua & ub;
            default: r = ua | ub;
        endcase
        return {(r >= 8), (r == 0), c, v, r[3:0]};
    endfunction

    function automatic logic [3:0] fx(input logic [3:0] f);
`ifdef REG_EXEC_FLAGS_EN
        return f;
`else
        return 4'b0000;
`endif
    endfunction

    int         m_age = 0;
    logic [7:0] m_instr = 8'h00;
    logic [7:0] m_out = 8'h00;
    logic [3:0] m_flags = 4'b0000;
    logic [3:0] m_regs [4];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_age   <= 0;
            m_flags <= 4'b0000;
        end else begin
            if (pl_en) m_regs[pl_a] <= pl_d;
            case (m_age)
                0: if (bus.instr_valid) begin
                    m_age   <= 1;
                    m_instr <= bus.instr;
                    m_out   <= model_exec(bus.instr[7:6], m_regs[bus.instr[3:2]], m_regs[bus.instr[1:0]]);
                end
                1: m_age <= 2;
                2: begin m_age <= 3; m_flags <= fx(m_out[7:4]); end
                default: begin m_age <= 0; m_regs[m_instr[5:4]] <= m_out[3:0]; end
            endcase
        end
    end

    always @(negedge clk) begin
        cyc++;
        check("ready", bus.instr_ready, (m_age == 0));
        check("we3", bus.WE3, (m_age == 3));
        check("done", bus.done, (m_age == 3));
        check("flags", bus.flags, m_flags);
        if (m_age == 1) begin
            check("a1", bus.A1, m_instr[3:2]);
            check("a2", bus.A2, m_instr[1:0]);
        end
        if (m_age == 3) begin
            check("a3", bus.A3, m_instr[5:4]);
            check("wd3", bus.WD3, m_out[3:0]);
        end
        if (bus.WE3 === 1'b1) pulses.push_back(cyc);
        for (int i = 0; i < 4; i++) check("regfile", regs[i], m_regs[i]);
    end

    task automatic set_reg(input logic [1:0] a, input logic [3:0] d);
        pl_en = 1'b1; pl_a = a; pl_d = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic issue(input logic [7:0] ins);
        bus.instr = ins; bus.instr_valid = 1'b1;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin regs[i] = 4'd0; m_regs[i] = 4'd0; end
        bus.instr = 8'h00;
        bus.instr_valid = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_ready", bus.instr_ready, 1);
        check("rst_we3", bus.WE3, 0);
        check("rst_done", bus.done, 0);
        check("rst_flags", bus.flags, 0);
        check("rst_a1", bus.A1, 0);
        check("rst_a2", bus.A2, 0);
        check("rst_a3", bus.A3, 0);
        check("rst_wd3", bus.WD3, 0);
        rst = 1'b0;
        @(negedge clk);

        // ADD with carry: 9 + 8 = 1, C=1, signed -7 + -8 overflows so V=1
        set_reg(2'd1, 4'd9);
        set_reg(2'd2, 4'd8);
        bus.instr = 8'h36; bus.instr_valid = 1'b1;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        check("add_a1", bus.A1, 1);
        check("add_a2", bus.A2, 2);
        check("add_busy", bus.instr_ready, 0);
        @(negedge clk);
        check("add_no_we_exec", bus.WE3, 0);
        @(negedge clk);
        check("add_we3", bus.WE3, 1);
        check("add_done", bus.done, 1);
        check("add_a3", bus.A3, 3);
        check("add_wd3", bus.WD3, 4'h1);
        @(negedge clk);
        check("add_r3", regs[3], 4'h1);
        check("add_flags", bus.flags, fx(4'b0011));

        // SUB with overflow, then SUB to zero
        set_reg(2'd1, 4'd8);
        set_reg(2'd2, 4'd1);
        issue(8'h76);
        check("sub_r3", regs[3], 4'h7);
        check("sub_flags", bus.flags, fx(4'b0011));
        set_reg(2'd1, 4'd5);
        set_reg(2'd2, 4'd5);
        issue(8'h76);
        check("subz_r3", regs[3], 4'h0);
        check("subz_flags", bus.flags, fx(4'b0110));

        // AND in place (rd=rs1), then ORR into rs2
        set_reg(2'd0, 4'hC);
        set_reg(2'd1, 4'hA);
        issue(8'h81);
        check("and_r0", regs[0], 4'h8);
        check("and_flags", bus.flags, fx(4'b1000));
        issue(8'hD1);
        check("orr_r1", regs[1], 4'hA);
        check("orr_flags", bus.flags, fx(4'b1000));

        // Throughput: valid held high, instr scrambled while busy
        pulses.delete();
        bus.instr = 8'h21; bus.instr_valid = 1'b1;
        @(negedge clk); bus.instr = 8'hFF;
        @(negedge clk);
        @(negedge clk); bus.instr = 8'h74;
        @(negedge clk); check("tp_ready_gap", bus.instr_ready, 1);
        @(negedge clk); bus.instr = 8'hFF;
        @(negedge clk);
        @(negedge clk); bus.instr = 8'hC6;
        @(negedge clk);
        @(negedge clk); bus.instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("tp_pulses", pulses.size(), 3);
        if (pulses.size() == 3) begin
            check("tp_space1", pulses[1] - pulses[0], 4);
            check("tp_space2", pulses[2] - pulses[1], 4);
        end
        check("tp_r2", regs[2], 4'h2);
        check("tp_r3", regs[3], 4'h2);
        check("tp_r0", regs[0], 4'hA);
        check("tp_flags", bus.flags, fx(4'b1000));

        // Asynchronous reset during EXEC discards the instruction
        bus.instr = 8'h31; bus.instr_valid = 1'b1;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        @(negedge clk);
        check("rm_flags_before", bus.flags, fx(4'b1000));
        #2 rst = 1'b1;
        #1;
        check("rm_we3", bus.WE3, 0);
        check("rm_done", bus.done, 0);
        check("rm_ready", bus.instr_ready, 1);
        check("rm_flags", bus.flags, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rm_r3_kept", regs[3], 4'h2);

        // Dependent back-to-back ADD R1 = R1 + R1
        set_reg(2'd1, 4'd3);
        issue(8'h15);
        check("dep1_r1", regs[1], 4'h6);
        check("dep1_flags", bus.flags, fx(4'b0000));
        issue(8'h15);
        check("dep2_r1", regs[1], 4'hC);
        check("dep2_flags", bus.flags, fx(4'b1001));

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
